// File: rtl/rtc_bus_arbiter.sv
// Round-robin arbiter for the multiplexed RTC address/data bus. Three clients
// (init sequencer, periodic reader, setting writer) compete. The winner gets one
// full bus cycle: address phase with ad high, ad falling edge, cs low, then a rd
// or wr strobe, hold, and recovery. All outputs come straight from flops.
module rtc_bus_arbiter #(
   parameter int unsigned ADDR_CYC   = 2,
   parameter int unsigned STROBE_CYC = 4,
   parameter int unsigned RECOV_CYC  = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  req,
   input  logic [2:0]  we,
   input  logic [23:0] addr,
   input  logic [23:0] wdata,
   output logic [2:0]  gnt,
   output logic [2:0]  done,
   output logic [7:0]  rdata,
   output logic        cs,
   output logic        ad,
   output logic        rd,
   output logic        wr,
   output logic [7:0]  ADout,
   output logic        ad_oe,
   input  logic [7:0]  ADin
);

   localparam int unsigned MaxAs  = (ADDR_CYC > STROBE_CYC) ? ADDR_CYC : STROBE_CYC;
   localparam int unsigned MaxCyc = (MaxAs > RECOV_CYC) ? MaxAs : RECOV_CYC;
   localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

   localparam logic [CntW-1:0] AddrLd   = CntW'(ADDR_CYC - 1);
   localparam logic [CntW-1:0] StrobeLd = CntW'(STROBE_CYC - 1);
   localparam logic [CntW-1:0] RecovLd  = CntW'(RECOV_CYC - 1);

   typedef enum logic [2:0] {
      StIdle, StAddr, StLatch, StSetup, StStrobe, StHold, StRecov, StDone
   } state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [1:0]        ptr_q, ptr_d;
   logic [1:0]        win_q, win_d;
   logic              we_l_q, we_l_d;
   logic [7:0]        addr_l_q, addr_l_d;
   logic [7:0]        wdata_l_q, wdata_l_d;
   logic [7:0]        rdata_q, rdata_d;
   logic [2:0]        gnt_q, gnt_d;
   logic [2:0]        done_q, done_d;
   logic              cs_q, cs_d;
   logic              ad_q, ad_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic              ad_oe_q, ad_oe_d;
   logic [7:0]        adout_q, adout_d;

   logic              found;
   logic [1:0]        pick;
   logic [1:0]        cand;
   logic [2:0]        win_oh;

   // Round-robin search: first requester upward (mod 3) from the last winner.
   always_comb begin
      found = 1'b0;
      pick  = ptr_q;
      cand  = 2'd0;
      for (int unsigned i = 1; i <= 3; i++) begin
         cand = 2'((32'(ptr_q) + i) % 32'd3);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   // Next state, client snapshot, and registered outputs decoded from the next state.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ptr_d     = ptr_q;
      win_d     = win_q;
      we_l_d    = we_l_q;
      addr_l_d  = addr_l_q;
      wdata_l_d = wdata_l_q;
      rdata_d   = rdata_q;

      unique case (state_q)
         StIdle: begin
            if (found) begin
               state_d   = StAddr;
               cnt_d     = AddrLd;
               ptr_d     = pick;
               win_d     = pick;
               we_l_d    = we[pick];
               addr_l_d  = addr[{pick, 3'b000} +: 8];
               wdata_l_d = wdata[{pick, 3'b000} +: 8];
            end
         end
         StAddr: begin
            if (cnt_q == '0) state_d = StLatch;
            else             cnt_d   = cnt_q - CntW'(1);
         end
         StLatch: state_d = StSetup;
         StSetup: begin
            state_d = StStrobe;
            cnt_d   = StrobeLd;
         end
         StStrobe: begin
            if (cnt_q == '0) begin
               state_d = StHold;
               // Capture read data only on the final strobe cycle.
               if (!we_l_q) rdata_d = ADin;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StHold: begin
            state_d = StRecov;
            cnt_d   = RecovLd;
         end
         StRecov: begin
            if (cnt_q == '0) state_d = StDone;
            else             cnt_d   = cnt_q - CntW'(1);
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      gnt_d   = 3'b000;
      done_d  = 3'b000;
      cs_d    = 1'b1;
      ad_d    = 1'b1;
      rd_d    = 1'b1;
      wr_d    = 1'b1;
      ad_oe_d = 1'b0;
      adout_d = adout_q;
      win_oh  = 3'b001 << win_d;

      unique case (state_d)
         StAddr: begin
            gnt_d   = win_oh;
            ad_oe_d = 1'b1;
            adout_d = addr_l_d;
         end
         StLatch: begin
            gnt_d   = win_oh;
            ad_d    = 1'b0;
            ad_oe_d = 1'b1;
            adout_d = addr_l_d;
         end
         StSetup, StHold: begin
            gnt_d   = win_oh;
            cs_d    = 1'b0;
            ad_d    = 1'b0;
            ad_oe_d = we_l_d;
            if (we_l_d) adout_d = wdata_l_d;
         end
         StStrobe: begin
            gnt_d   = win_oh;
            cs_d    = 1'b0;
            ad_d    = 1'b0;
            ad_oe_d = we_l_d;
            rd_d    = we_l_d;
            wr_d    = !we_l_d;
            if (we_l_d) adout_d = wdata_l_d;
         end
         StRecov: gnt_d  = win_oh;
         StDone:  done_d = win_oh;
         default: ;
      endcase
   end

   // State and output registers; pointer resets to 2 so client 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         ptr_q     <= 2'd2;
         win_q     <= 2'd0;
         we_l_q    <= 1'b0;
         addr_l_q  <= 8'h00;
         wdata_l_q <= 8'h00;
         rdata_q   <= 8'h00;
         gnt_q     <= 3'b000;
         done_q    <= 3'b000;
         cs_q      <= 1'b1;
         ad_q      <= 1'b1;
         rd_q      <= 1'b1;
         wr_q      <= 1'b1;
         ad_oe_q   <= 1'b0;
         adout_q   <= 8'h00;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         win_q     <= win_d;
         we_l_q    <= we_l_d;
         addr_l_q  <= addr_l_d;
         wdata_l_q <= wdata_l_d;
         rdata_q   <= rdata_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         cs_q      <= cs_d;
         ad_q      <= ad_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         ad_oe_q   <= ad_oe_d;
         adout_q   <= adout_d;
      end
   end

   assign gnt   = gnt_q;
   assign done  = done_q;
   assign rdata = rdata_q;
   assign cs    = cs_q;
   assign ad    = ad_q;
   assign rd    = rd_q;
   assign wr    = wr_q;
   assign ad_oe = ad_oe_q;
   assign ADout = adout_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Bench for rtc_bus_arbiter: default-parameter instance plus a 1/1/1 instance
// sharing the same inputs. A transaction-level model predicts grant order and
// the per-cycle bus waveform from phase lengths.
module tb_rtc_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  req, we;
   logic [23:0] addr, wdata;
   logic [7:0]  ADin;

   logic [2:0] g0, d0, g1, d1;
   logic [7:0] rdata0, rdata1, adout0, adout1;
   logic       cs0, ad0, rd0, wr0, oe0, cs1, ad1, rd1, wr1, oe1;

   logic       sel;
   logic [2:0] m_gnt, m_done;
   logic [7:0] m_rdata, m_adout;
   logic       m_cs, m_ad, m_rd, m_wr, m_oe;

   int n_checks = 0;
   int n_fail   = 0;
   int cur_a, cur_s, cur_r;
   int mdl_ptr;
   logic [7:0] mdl_rdata;
   bit hit;

   typedef struct {
      int         c;
      logic       w;
      logic [7:0] a;
      logic [7:0] d;
      logic [7:0] din;
      logic [7:0] er;
   } vec_t;
   vec_t tbl[6];

   always #5 clk = ~clk;

   rtc_bus_arbiter #(.ADDR_CYC(2), .STROBE_CYC(4), .RECOV_CYC(2)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .gnt(g0), .done(d0), .rdata(rdata0), .cs(cs0), .ad(ad0), .rd(rd0), .wr(wr0),
      .ADout(adout0), .ad_oe(oe0), .ADin(ADin)
   );

   rtc_bus_arbiter #(.ADDR_CYC(1), .STROBE_CYC(1), .RECOV_CYC(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .gnt(g1), .done(d1), .rdata(rdata1), .cs(cs1), .ad(ad1), .rd(rd1), .wr(wr1),
      .ADout(adout1), .ad_oe(oe1), .ADin(ADin)
   );

   assign m_gnt   = sel ? g1 : g0;
   assign m_done  = sel ? d1 : d0;
   assign m_rdata = sel ? rdata1 : rdata0;
   assign m_adout = sel ? adout1 : adout0;
   assign m_cs    = sel ? cs1 : cs0;
   assign m_ad    = sel ? ad1 : ad0;
   assign m_rd    = sel ? rd1 : rd0;
   assign m_wr    = sel ? wr1 : wr0;
   assign m_oe    = sel ? oe1 : oe0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [2:0] m, input int p);
      for (int i = 1; i <= 3; i++) if (m[(p + i) % 3]) return (p + i) % 3;
      return -1;
   endfunction

   task automatic new_req(input int c);
      req[c]            = 1'b1;
      we[c]             = 1'($urandom);
      addr[8*c +: 8]    = 8'($urandom);
      wdata[8*c +: 8]   = 8'($urandom);
   endtask

   // One transaction: wait for grant, then check every cycle against the phase plan.
   task automatic run_one(input int exp_c, input bit drop, input int exp_wait,
                          input logic [7:0] rd_val);
      int         waits, len, lst, ph;
      bit         got;
      logic [2:0] oh;
      logic       e_we, ecs, erd, ewr, eoe;
      logic [7:0] e_addr, e_wdata;
      waits = 0;
      got   = 1'b0;
      oh    = 3'(3'b001 << exp_c);
      for (int k = 0; k < 30 && !got; k++) begin
         @(negedge clk);
         if (m_gnt != 3'b000) got = 1'b1;
         else begin
            waits++;
            chk("idle_done", 32'(m_done), 32'd0);
            chk("idle_bus", 32'({m_cs, m_rd, m_wr, m_oe}), 32'b1110);
         end
      end
      if (!got) begin
         n_checks++;
         n_fail++;
         $display("FAIL grant_timeout: got no grant expected client %0d", exp_c);
         return;
      end
      if (exp_wait >= 0) chk("grant_gap", 32'(waits), 32'(exp_wait));
      chk("gnt", 32'(m_gnt), 32'(oh));
      e_we    = we[exp_c];
      e_addr  = addr[8*exp_c +: 8];
      e_wdata = wdata[8*exp_c +: 8];
      // Client inputs change after grant; the bus must keep the snapshot.
      addr[8*exp_c +: 8]  = ~e_addr;
      wdata[8*exp_c +: 8] = ~e_wdata;
      len = cur_a + 3 + cur_s + cur_r;
      lst = cur_a + 1 + cur_s;
      for (int c = 0; c < len; c++) begin
         if (c > 0) @(negedge clk);
         ph  = (c < cur_a) ? 0 : (c == cur_a) ? 1 : (c == cur_a + 1) ? 2 :
               (c <= lst) ? 3 : (c == lst + 1) ? 4 : 5;
         ecs = !(ph inside {2, 3, 4});
         erd = !(ph == 3 && !e_we);
         ewr = !(ph == 3 && e_we);
         eoe = (ph <= 1) || ((ph inside {2, 3, 4}) && e_we);
         chk("gnt_hold", 32'(m_gnt), 32'(oh));
         chk("done_early", 32'(m_done), 32'd0);
         chk("strobes", 32'({m_cs, m_rd, m_wr, m_oe}), 32'({ecs, erd, ewr, eoe}));
         if (ph == 0 || ph == 5) chk("ad_high", 32'(m_ad), 32'd1);
         if (ph == 1) chk("ad_low", 32'(m_ad), 32'd0);
         if (eoe) chk("adout", 32'(m_adout), 32'((ph <= 1) ? e_addr : e_wdata));
         if (c <= lst) chk("rdata_stable", 32'(m_rdata), 32'(mdl_rdata));
         if (!e_we && ph == 3) ADin = (c == lst) ? rd_val : ~rd_val;
         else                  ADin = 8'($urandom);
      end
      @(negedge clk);
      if (!e_we) mdl_rdata = rd_val;
      chk("done", 32'(m_done), 32'(oh));
      chk("gnt_done", 32'(m_gnt), 32'd0);
      chk("rdata", 32'(m_rdata), 32'(mdl_rdata));
      chk("done_bus", 32'({m_cs, m_rd, m_wr, m_oe}), 32'b1110);
      if (drop) req[exp_c] = 1'b0;
      mdl_ptr = exp_c;
   endtask

   task automatic run_table();
      for (int i = 0; i < 6; i++) begin
         req                       = 3'b000;
         req[tbl[i].c]             = 1'b1;
         we[tbl[i].c]              = tbl[i].w;
         addr[8*tbl[i].c +: 8]     = tbl[i].a;
         wdata[8*tbl[i].c +: 8]    = tbl[i].d;
         run_one(tbl[i].c, 1'b1, -1, tbl[i].din);
         chk("tbl_rdata", 32'(m_rdata), 32'(tbl[i].er));
      end
   endtask

   initial begin
      tbl[0] = '{c: 0, w: 1'b1, a: 8'h0B, d: 8'h86, din: 8'hEE, er: 8'h00};
      tbl[1] = '{c: 1, w: 1'b0, a: 8'h00, d: 8'h11, din: 8'h37, er: 8'h37};
      tbl[2] = '{c: 2, w: 1'b1, a: 8'h0A, d: 8'h26, din: 8'h99, er: 8'h37};
      tbl[3] = '{c: 2, w: 1'b0, a: 8'h0C, d: 8'h00, din: 8'hA5, er: 8'hA5};
      tbl[4] = '{c: 0, w: 1'b0, a: 8'h7F, d: 8'h33, din: 8'h5A, er: 8'h5A};
      tbl[5] = '{c: 1, w: 1'b1, a: 8'hFF, d: 8'h00, din: 8'h44, er: 8'h5A};

      rst_n = 1'b0; sel = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; ADin = '0;
      cur_a = 2; cur_s = 4; cur_r = 2; mdl_ptr = 2; mdl_rdata = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_bus", 32'({m_cs, m_ad, m_rd, m_wr, m_oe}), 32'b11110);
      chk("rst_gnt_done", 32'({m_gnt, m_done}), 32'd0);
      chk("rst_data", 32'({m_adout, m_rdata}), 32'd0);
      rst_n = 1'b1;

      // Contention: all three held high, writes only.
      req = 3'b111; we = 3'b111;
      addr = 24'(($urandom)); wdata = 24'($urandom);
      for (int k = 0; k < 4; k++) run_one(rr_pick(req, mdl_ptr), 1'b0, (k == 0) ? -1 : 1, 8'h00);
      req = 3'b000;

      run_table();

      // Randomized mixes of pending requests against the round-robin model.
      for (int n = 0; n < 40; n++) begin
         for (int c = 0; c < 3; c++) if (!req[c] && $urandom_range(1, 0) == 1) new_req(c);
         if (req == 3'b000) new_req(n % 3);
         run_one(rr_pick(req, mdl_ptr), 1'b1, (n == 0) ? -1 : 1, 8'($urandom));
      end
      req = 3'b000;

      // Reset in the middle of a write strobe.
      new_req(0);
      we[0] = 1'b1;
      hit   = 1'b0;
      for (int k = 0; k < 40 && !hit; k++) begin
         @(negedge clk);
         if (m_wr == 1'b0) hit = 1'b1;
      end
      if (!hit) begin
         n_checks++;
         n_fail++;
         $display("FAIL strobe_timeout: got no wr strobe expected one");
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_bus", 32'({m_cs, m_ad, m_rd, m_wr, m_oe}), 32'b11110);
      chk("async_rst_gnt_done", 32'({m_gnt, m_done}), 32'd0);
      chk("async_rst_data", 32'({m_adout, m_rdata}), 32'd0);
      req = 3'b000;
      new_req(1);
      new_req(0);
      mdl_ptr = 2; mdl_rdata = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_held_done", 32'(m_done), 32'd0);
      rst_n = 1'b1;
      run_one(rr_pick(req, mdl_ptr), 1'b1, -1, 8'($urandom));
      run_one(rr_pick(req, mdl_ptr), 1'b1, 1, 8'($urandom));

      // Minimum-parameter instance.
      rst_n = 1'b0; req = 3'b000; sel = 1'b1;
      cur_a = 1; cur_s = 1; cur_r = 1; mdl_ptr = 2; mdl_rdata = 8'h00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_table();
      req = 3'b111; we = 3'b010;
      for (int k = 0; k < 4; k++) run_one(rr_pick(req, mdl_ptr), 1'b0, (k == 0) ? -1 : 1, 8'($urandom));
      req = 3'b000;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
